// File: rtl/event_pkt_pkg.sv
// Shared definitions for the LArPix event packet decoder: field layout, packet
// type code, trigger-type and FSM state enums, and the packed field record.
package event_pkt_pkg;

  localparam int PKT_W         = 64;
  localparam int TYPE_LSB      = 0;
  localparam int TYPE_W        = 2;
  localparam int CHIP_ID_LSB   = 2;
  localparam int CHIP_ID_W     = 8;
  localparam int CHANNEL_LSB   = 10;
  localparam int CHANNEL_W     = 6;
  localparam int TS_LSB        = 16;
  localparam int TS_W          = 32;
  localparam int FIRST_PKT_BIT = 47;
  localparam int ADC_LSB       = 48;
  localparam int ADC_W         = 10;
  localparam int TRIG_LSB      = 58;
  localparam int TRIG_W        = 2;
  localparam int FSTAT_LSB     = 60;
  localparam int FSTAT_W       = 2;
  localparam int DS_BIT        = 62;
  localparam int PARITY_BIT    = 63;

  localparam logic [TYPE_W-1:0] PKT_TYPE_DATA = 2'b01;

  typedef enum logic [TRIG_W-1:0] {
    TRIG_NATURAL  = 2'd0,
    TRIG_EXTERNAL = 2'd1,
    TRIG_CROSS    = 2'd2,
    TRIG_PERIODIC = 2'd3
  } trig_type_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_LOAD  = 2'd2,
    ST_HOLD  = 2'd3
  } dec_state_e;

  // Bits [DS_BIT:CHIP_ID_LSB] of a packet, MSB first, so a slice casts directly.
  typedef struct packed {
    logic                 downstream;
    logic [FSTAT_W-1:0]   fifo_status;
    trig_type_e           trigger;
    logic [ADC_W-1:0]     adc;
    logic [TS_W-1:0]      timestamp;
    logic [CHANNEL_W-1:0] channel;
    logic [CHIP_ID_W-1:0] chip;
  } evt_fields_t;

  // Odd parity: a good packet has an odd number of ones over all 64 bits.
  function automatic logic parity_ok(input logic [PKT_W-1:0] pkt);
    return ^pkt;
  endfunction

endpackage

// File: rtl/event_pkt_decoder_hit_counter_bank.sv
// Per-channel 16-bit saturating hit counters with a combinational read port.
// Only instantiated when EVENT_PKT_DECODER_HIT_COUNTERS_EN is defined.
module hit_counter_bank #(
  parameter int NUMCHANNELS = 64,
  parameter int SEL_W       = $clog2(NUMCHANNELS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             inc_i,
  input  logic [SEL_W-1:0] inc_sel_i,
  input  logic [SEL_W-1:0] rd_sel_i,
  output logic [15:0]      rd_count_o
);

  logic [15:0] count_q [NUMCHANNELS];

  // NOTE: the bank must read zero after reset/clear, so every entry is reset
  // explicitly; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      for (int i = 0; i < NUMCHANNELS; i++) count_q[i] <= '0;
    end else if (inc_i && (count_q[inc_sel_i] != 16'hFFFF)) begin
      count_q[inc_sel_i] <= count_q[inc_sel_i] + 16'd1;
    end
  end

  assign rd_count_o = count_q[rd_sel_i];

endmodule

// File: rtl/event_pkt_decoder.sv
// Pulls LArPix packets from the shared event FIFO, checks odd parity, filters,
// decodes and holds each event on a valid/ready port. Hit counters: EVENT_PKT_DECODER_HIT_COUNTERS_EN.
module event_pkt_decoder
  import event_pkt_pkg::*;
#(
  parameter int NUMCHANNELS = 64,
  parameter int WIDTH       = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [WIDTH-1:0]               fifo_dout,
  input  logic                           fifo_empty,
  output logic                           read_fifo_n,
  output logic                           evt_valid,
  input  logic                           evt_ready,
  output logic [7:0]                     chip_id,
  output logic [5:0]                     channel_id,
  output logic [31:0]                    timestamp_32b,
  output logic                           first_packet,
  output logic [9:0]                     adc_word,
  output logic [1:0]                     trigger_type,
  output logic [1:0]                     fifo_status,
  output logic                           downstream,
  output logic                           parity_err,
  input  logic                           enable_chip_filter,
  input  logic [7:0]                     chip_id_filter,
  input  logic                           drop_bad_parity,
  input  logic                           clear_counts,
  output logic [31:0]                    pkt_count,
  output logic [15:0]                    parity_err_count,
  output logic [15:0]                    drop_count,
  input  logic [$clog2(NUMCHANNELS)-1:0] hit_count_sel,
  output logic [15:0]                    hit_count
);

  dec_state_e  state_q, state_d;
  evt_fields_t in_fields, fields_q;
  logic        read_n_q, evt_valid_q, parity_err_q;
  logic        par_fail, drop, load_evt;
  logic [31:0] pkt_count_q;
  logic [15:0] parity_err_count_q, drop_count_q;

  assign in_fields = evt_fields_t'(fifo_dout[DS_BIT:CHIP_ID_LSB]);
  assign par_fail  = !parity_ok(fifo_dout);
  assign drop      = (fifo_dout[TYPE_LSB +: TYPE_W] != PKT_TYPE_DATA)
                  || (enable_chip_filter && (in_fields.chip != chip_id_filter))
                  || (par_fail && drop_bad_parity);
  assign load_evt  = (state_q == ST_LOAD) && !drop;

  // NOTE: state_d gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (!fifo_empty) state_d = ST_FETCH;
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD:  state_d = drop ? ST_IDLE : ST_HOLD;
      ST_HOLD:  if (evt_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      read_n_q     <= 1'b1;
      evt_valid_q  <= 1'b0;
      fields_q     <= '0;
      parity_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      read_n_q    <= (state_d != ST_FETCH);
      evt_valid_q <= (state_d == ST_HOLD);
      if (load_evt) begin
        fields_q     <= in_fields;
        parity_err_q <= par_fail;
      end
    end
  end

  // Clear shares the reset branch, so a coincident increment is discarded.
  always_ff @(posedge clk) begin
    if (reset || clear_counts) begin
      pkt_count_q        <= '0;
      parity_err_count_q <= '0;
      drop_count_q       <= '0;
    end else if (state_q == ST_LOAD) begin
      if (!drop)                       pkt_count_q  <= pkt_count_q + 32'd1;
      else if (drop_count_q != 16'hFFFF) drop_count_q <= drop_count_q + 16'd1;
      if (par_fail && (parity_err_count_q != 16'hFFFF))
        parity_err_count_q <= parity_err_count_q + 16'd1;
    end
  end

  assign read_fifo_n      = read_n_q;
  assign evt_valid        = evt_valid_q;
  assign chip_id          = fields_q.chip;
  assign channel_id       = fields_q.channel;
  assign timestamp_32b    = fields_q.timestamp;
  assign first_packet     = fields_q.timestamp[FIRST_PKT_BIT-TS_LSB];
  assign adc_word         = fields_q.adc;
  assign trigger_type     = fields_q.trigger;
  assign fifo_status      = fields_q.fifo_status;
  assign downstream       = fields_q.downstream;
  assign parity_err       = parity_err_q;
  assign pkt_count        = pkt_count_q;
  assign parity_err_count = parity_err_count_q;
  assign drop_count       = drop_count_q;

`ifdef EVENT_PKT_DECODER_HIT_COUNTERS_EN
  hit_counter_bank #(
    .NUMCHANNELS (NUMCHANNELS)
  ) u_hit_counter_bank (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (clear_counts),
    .inc_i      (load_evt),
    .inc_sel_i  (in_fields.channel[$clog2(NUMCHANNELS)-1:0]),
    .rd_sel_i   (hit_count_sel),
    .rd_count_o (hit_count)
  );
`else
  logic unused_hit_sel;
  assign unused_hit_sel = ^hit_count_sel;
  assign hit_count      = '0;
`endif

endmodule

// File: tb/tb_event_pkt_decoder.sv
// Directed bench for event_pkt_decoder: a queue models the shared FIFO, and
// expected field values come from the hand-written stimulus records.
module tb_event_pkt_decoder;

  typedef struct {
    logic [7:0]  chip;
    logic [5:0]  ch;
    logic [31:0] ts;
    logic [9:0]  adc;
    logic [1:0]  trig;
    logic [1:0]  fs;
    logic        ds;
  } evt_t;

`ifdef EVENT_PKT_DECODER_HIT_COUNTERS_EN
  localparam bit HC_EN = 1'b1;
`else
  localparam bit HC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] fifo_dout = '0;
  logic        fifo_empty = 1'b1;
  logic        read_fifo_n, evt_valid;
  logic        evt_ready = 1'b0;
  logic [7:0]  chip_id;
  logic [5:0]  channel_id;
  logic [31:0] timestamp_32b;
  logic        first_packet;
  logic [9:0]  adc_word;
  logic [1:0]  trigger_type, fifo_status;
  logic        downstream, parity_err;
  logic        enable_chip_filter = 1'b0;
  logic [7:0]  chip_id_filter = '0;
  logic        drop_bad_parity = 1'b0;
  logic        clear_counts = 1'b0;
  logic [31:0] pkt_count;
  logic [15:0] parity_err_count, drop_count;
  logic [5:0]  hit_count_sel = '0;
  logic [15:0] hit_count;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] fifo_q [$];

  event_pkt_decoder dut (
    .clk(clk), .reset(reset), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .read_fifo_n(read_fifo_n), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .chip_id(chip_id), .channel_id(channel_id), .timestamp_32b(timestamp_32b),
    .first_packet(first_packet), .adc_word(adc_word), .trigger_type(trigger_type),
    .fifo_status(fifo_status), .downstream(downstream), .parity_err(parity_err),
    .enable_chip_filter(enable_chip_filter), .chip_id_filter(chip_id_filter),
    .drop_bad_parity(drop_bad_parity), .clear_counts(clear_counts),
    .pkt_count(pkt_count), .parity_err_count(parity_err_count),
    .drop_count(drop_count), .hit_count_sel(hit_count_sel), .hit_count(hit_count)
  );

  always #5 clk = ~clk;

  // FIFO model: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (read_fifo_n == 1'b0 && fifo_q.size() > 0) fifo_dout <= fifo_q.pop_front();
  end
  always @(negedge clk) fifo_empty = (fifo_q.size() == 0);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] build(input evt_t e, input logic [1:0] typ, input bit bad);
    logic [63:0] p;
    p = {1'b0, e.ds, e.fs, e.trig, e.adc, e.ts, e.ch, e.chip, typ};
    p[63] = ~^p[62:0];
    if (bad) p[63] = ~p[63];
    return p;
  endfunction

  task automatic push(input evt_t e, input logic [1:0] typ, input bit bad);
    fifo_q.push_back(build(e, typ, bad));
  endtask

  task automatic check_evt(input string tag, input evt_t e, input logic perr);
    check({tag, "_chip"},  chip_id, e.chip);
    check({tag, "_chan"},  channel_id, e.ch);
    check({tag, "_ts"},    timestamp_32b, e.ts);
    check({tag, "_first"}, first_packet, e.ts[31]);
    check({tag, "_adc"},   adc_word, e.adc);
    check({tag, "_trig"},  trigger_type, e.trig);
    check({tag, "_fstat"}, fifo_status, e.fs);
    check({tag, "_ds"},    downstream, e.ds);
    check({tag, "_perr"},  parity_err, perr);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (evt_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_valid_timeout"}, evt_valid, 1'b1);
  endtask

  task automatic accept(input string tag);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    check({tag, "_valid_drop"}, evt_valid, 1'b0);
  endtask

  task automatic watch_idle(input int cycles, output bit saw_valid);
    saw_valid = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (evt_valid === 1'b1) saw_valid = 1'b1;
    end
  endtask

  task automatic pulse_clear();
    clear_counts = 1'b1;
    tick();
    clear_counts = 1'b0;
  endtask

  initial begin
    evt_t a, b, c, d, e, f, g;
    bit saw;

    a = '{chip: 8'h2A, ch: 6'd5,  ts: 32'h0000_1234, adc: 10'd723,  trig: 2'b00, fs: 2'b00, ds: 1'b0};
    b = '{chip: 8'h2A, ch: 6'd7,  ts: 32'h8000_0001, adc: 10'd1,    trig: 2'b10, fs: 2'b01, ds: 1'b1};
    c = '{chip: 8'h2A, ch: 6'd9,  ts: 32'hAAAA_5555, adc: 10'd1023, trig: 2'b11, fs: 2'b10, ds: 1'b0};
    d = '{chip: 8'h11, ch: 6'd63, ts: 32'hFFFF_FFFF, adc: 10'd512,  trig: 2'b01, fs: 2'b11, ds: 1'b1};
    e = '{chip: 8'h2B, ch: 6'd1,  ts: 32'h0000_0042, adc: 10'd7,    trig: 2'b01, fs: 2'b00, ds: 1'b0};
    f = '{chip: 8'h2A, ch: 6'd63, ts: 32'h0000_0099, adc: 10'd300,  trig: 2'b00, fs: 2'b00, ds: 1'b0};
    g = '{chip: 8'h2B, ch: 6'd2,  ts: 32'h1357_9BDF, adc: 10'd11,   trig: 2'b11, fs: 2'b01, ds: 1'b1};

    // Reset state
    tick();
    tick();
    reset = 1'b0;
    check("rst_read_n", read_fifo_n, 1'b1);
    check("rst_valid", evt_valid, 1'b0);
    check("rst_chip", chip_id, 8'h00);
    check("rst_ts", timestamp_32b, 32'h0);
    check("rst_perr", parity_err, 1'b0);
    check("rst_pkt_count", pkt_count, 32'd0);
    check("rst_perr_count", parity_err_count, 16'd0);
    check("rst_drop_count", drop_count, 16'd0);
    check("rst_hit_count", hit_count, 16'd0);

    // Single packet: FETCH, LOAD, then HOLD
    push(a, 2'b01, 1'b0);
    tick();
    check("a_read_low", read_fifo_n, 1'b0);
    check("a_valid_c1", evt_valid, 1'b0);
    tick();
    check("a_read_high", read_fifo_n, 1'b1);
    check("a_valid_c2", evt_valid, 1'b0);
    tick();
    check("a_valid_c3", evt_valid, 1'b1);
    check_evt("a", a, 1'b0);
    check("a_pkt_count", pkt_count, 32'd1);
    accept("a");

    // Backpressure with two packets queued
    push(b, 2'b01, 1'b0);
    push(c, 2'b01, 1'b0);
    wait_valid("b");
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_read_n", read_fifo_n, 1'b1);
      check("bp_valid", evt_valid, 1'b1);
      check("bp_ts", timestamp_32b, b.ts);
    end
    check_evt("b", b, 1'b0);
    accept("b");
    wait_valid("c");
    check_evt("c", c, 1'b0);
    check("c_pkt_count", pkt_count, 32'd3);
    accept("c");

    // Parity failure delivered, then dropped
    push(d, 2'b01, 1'b1);
    wait_valid("d_keep");
    check_evt("d_keep", d, 1'b1);
    check("d_keep_perr_count", parity_err_count, 16'd1);
    check("d_keep_pkt_count", pkt_count, 32'd4);
    accept("d_keep");
    drop_bad_parity = 1'b1;
    push(d, 2'b01, 1'b1);
    watch_idle(8, saw);
    check("d_drop_no_valid", saw, 1'b0);
    check("d_drop_count", drop_count, 16'd1);
    check("d_drop_perr_count", parity_err_count, 16'd2);
    check("d_drop_pkt_count", pkt_count, 32'd4);
    drop_bad_parity = 1'b0;

    // Chip filter, wrong type, and a multi-reason drop
    pulse_clear();
    check("clr_pkt_count", pkt_count, 32'd0);
    check("clr_drop_count", drop_count, 16'd0);
    check("clr_perr_count", parity_err_count, 16'd0);
    enable_chip_filter = 1'b1;
    chip_id_filter = 8'h2A;
    push(a, 2'b01, 1'b0);
    push(e, 2'b01, 1'b0);
    push(a, 2'b10, 1'b0);
    wait_valid("flt_a");
    check("flt_a_chip", chip_id, 8'h2A);
    accept("flt_a");
    watch_idle(10, saw);
    check("flt_no_valid", saw, 1'b0);
    check("flt_drop_count", drop_count, 16'd2);
    check("flt_pkt_count", pkt_count, 32'd1);
    drop_bad_parity = 1'b1;
    push(g, 2'b11, 1'b1);
    watch_idle(6, saw);
    check("multi_no_valid", saw, 1'b0);
    check("multi_drop_count", drop_count, 16'd3);
    check("multi_perr_count", parity_err_count, 16'd1);
    drop_bad_parity = 1'b0;
    enable_chip_filter = 1'b0;

    // Reset while in LOAD: packet lost, nothing counted
    push(a, 2'b01, 1'b0);
    tick();
    check("rl_fetch", read_fifo_n, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rl_valid", evt_valid, 1'b0);
    check("rl_chip", chip_id, 8'h00);
    check("rl_pkt_count", pkt_count, 32'd0);
    check("rl_drop_count", drop_count, 16'd0);
    check("rl_perr_count", parity_err_count, 16'd0);
    watch_idle(6, saw);
    check("rl_no_stale", saw, 1'b0);
    check("rl_pkt_count2", pkt_count, 32'd0);

    // Saturation: counters preset near the top, then real parity drops push past it
    force dut.parity_err_count_q = 16'hFFFA;
    force dut.drop_count_q = 16'hFFFE;
    tick();
    release dut.parity_err_count_q;
    release dut.drop_count_q;
    drop_bad_parity = 1'b1;
    for (int i = 0; i < 8; i++) push(d, 2'b01, 1'b1);
    watch_idle(30, saw);
    check("sat_no_valid", saw, 1'b0);
    check("sat_perr_count", parity_err_count, 16'hFFFF);
    check("sat_drop_count", drop_count, 16'hFFFF);
    push(d, 2'b01, 1'b1);
    tick();
    tick();
    clear_counts = 1'b1;
    tick();
    clear_counts = 1'b0;
    check("clrwin_perr_count", parity_err_count, 16'd0);
    check("clrwin_drop_count", drop_count, 16'd0);
    drop_bad_parity = 1'b0;
    tick();

    // Hit counters: three hits on channel 5, one on channel 63
    push(a, 2'b01, 1'b0);
    push(a, 2'b01, 1'b0);
    push(a, 2'b01, 1'b0);
    push(f, 2'b01, 1'b0);
    for (int i = 0; i < 4; i++) begin
      wait_valid("hc");
      accept("hc");
    end
    check("hc_pkt_count", pkt_count, 32'd4);
    hit_count_sel = 6'd5;
    #1;
    check("hc_ch5", hit_count, HC_EN ? 16'd3 : 16'd0);
    hit_count_sel = 6'd63;
    #1;
    check("hc_ch63", hit_count, HC_EN ? 16'd1 : 16'd0);
    pulse_clear();
    check("hc_ch63_clr", hit_count, 16'd0);
    hit_count_sel = 6'd5;
    #1;
    check("hc_ch5_clr", hit_count, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
